// File: rtl/mfp_als_spi_responder_pkg.sv
// Shared constants for the ALS SPI responder: default frame geometry
// and the responder state encoding.
package mfp_als_spi_responder_pkg;

    localparam int MFP_ALS_LEAD_ZEROS  = 3;
    localparam int MFP_ALS_DATA_WIDTH  = 8;
    localparam int MFP_ALS_TRAIL_ZEROS = 4;
    localparam int MFP_ALS_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_SHIFT     = 2'd2
    } als_state_e;

endpackage

// File: rtl/mfp_sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous pin, with a synchronized
// level and single-cycle rise/fall pulses derived from it.
module mfp_sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain plus one history flop for edge detection.
    // Reset to 0 so a pin that is already high after reset is not taken
    // as a valid idle level until it has really propagated through.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  =  level_o & ~prev_q;
    assign fall_o  = ~level_o &  prev_q;

endmodule

// File: rtl/mfp_als_spi_responder.sv
// SPI slave emulating an ADC081S021-style ambient light sensor.
// Optional build macro: MFP_ALS_RESPONDER_RAMP_EN -- serve an internal
// ramp (incremented on each completed frame) instead of sample_in.
module mfp_als_spi_responder
    import mfp_als_spi_responder_pkg::*;
#(
    parameter int DATA_WIDTH  = MFP_ALS_DATA_WIDTH,
    parameter int LEAD_ZEROS  = MFP_ALS_LEAD_ZEROS,
    parameter int TRAIL_ZEROS = MFP_ALS_TRAIL_ZEROS,
    parameter int SYNC_STAGES = MFP_ALS_SYNC_STAGES
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  spi_cs,
    input  logic                  spi_sck,
    output logic                  spi_sdo,
    output logic                  spi_sdo_oe,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_abort
);

    localparam int FRAME_BITS = LEAD_ZEROS + DATA_WIDTH + TRAIL_ZEROS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(FRAME_BITS - 1);

    als_state_e              state_q, state_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    done_q, done_d;
    logic                    abort_q, abort_d;
    logic [DATA_WIDTH-1:0]   load_data;

    logic cs_level, cs_rise, cs_fall;
    logic sck_level_unused, sck_rise_unused, sck_fall;

    mfp_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk     (clk),
        .resetn  (resetn),
        .async_i (spi_cs),
        .level_o (cs_level),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    mfp_sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk     (clk),
        .resetn  (resetn),
        .async_i (spi_sck),
        .level_o (sck_level_unused),
        .rise_o  (sck_rise_unused),
        .fall_o  (sck_fall)
    );

`ifdef MFP_ALS_RESPONDER_RAMP_EN
    logic [DATA_WIDTH-1:0] ramp_q;
    logic                  unused_sample;

    // Test ramp: advances once per completed frame, aborts leave it alone.
    always_ff @(posedge clk) begin
        if (!resetn) ramp_q <= '0;
        else if (done_d) ramp_q <= ramp_q + 1'b1;
    end

    assign load_data     = ramp_q;
    assign unused_sample = ^sample_in;
`else
    assign load_data = sample_in;
`endif

    // State, shift register, counter and completion pulses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_WAIT_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    // Frame sequencing; a CS rise takes priority over a coincident SCK fall.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            ST_WAIT_IDLE: begin
                if (cs_level) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    shreg_d = FRAME_BITS'(load_data) << TRAIL_ZEROS;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    if (cnt_q >= CNT_DONE) done_d  = 1'b1;
                    else                   abort_d = 1'b1;
                end else if (sck_fall) begin
                    shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase
    end

    assign spi_sdo     = shreg_q[FRAME_BITS-1];
    assign busy        = (state_q == ST_SHIFT);
    assign spi_sdo_oe  = busy;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;

endmodule
